oldland_dbg_cr_master: RTL and testbench
========================================

# oldland_dbg_cr_master

Debug-side initiator for the execute stage's debug control-register port. It accepts control-register commands from the debug controller over a valid/ready channel and drives `dbg_cr_sel`, `dbg_cr_wr_en` and `dbg_cr_wr_val` into the execute stage. It samples `dbg_cr_val`, supports read-modify-write (set/clear bits) and read-back-after-write, and returns one response per command. Accesses are performed only while the CPU is stopped.

## Interface
- No parameters; CR index width fixed at 3, data width 32.
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- cpu_stopped  input  1  core halted by debug; sampled at command accept.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block idle and able to accept.
- cmd_op  input  2  00 READ, 01 WRITE, 10 SET (old|data), 11 CLEAR (old&~data).
- cmd_sel  input  3  control register index 0..7.
- cmd_data  input  32  write value or bit mask.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed.
- rsp_data  output  32  read value or post-write read-back value.
- rsp_err  output  1  command rejected, no CR access made.
- dbg_cr_sel  output  3  CR index to execute stage.
- dbg_cr_val  input  32  combinational CR read value for `dbg_cr_sel`.
- dbg_cr_wr_val  output  32  CR write data.
- dbg_cr_wr_en  output  1  one-cycle CR write strobe.

## Operation
- States: IDLE, SELECT, WRITE, READBACK, RESP. All outputs are registered or decoded from state only.
- **IDLE:** `cmd_ready=1`. On `cmd_valid&&cmd_ready`, latch op/sel/data and set `dbg_cr_sel<=cmd_sel`.
  - Reject to RESP with `rsp_err=1` and `rsp_data=0` if `!cpu_stopped`, or if op≠READ and sel==7 (CR7 is read-only zero).
  - Otherwise go to SELECT.
- **SELECT:** capture `old=dbg_cr_val`.
  - READ: `rsp_data<=old`, go to RESP.
  - WRITE: `dbg_cr_wr_val<=data`.
  - SET: `dbg_cr_wr_val<=old|data`.
  - CLEAR: `dbg_cr_wr_val<=old&~data`.
  - WRITE, SET and CLEAR go to WRITE.
- **WRITE:** `dbg_cr_wr_en=1` for exactly this cycle, `dbg_cr_sel` held. Go to READBACK.
- **READBACK:** `rsp_data<=dbg_cr_val`. This is the value after the write, which may differ from the written value because of masked bits such as the CR0 [5:0] and CR5/6 [1:0] zeros. Go to RESP.
- **RESP:** `rsp_valid=1`; `rsp_data` and `rsp_err` are stable until `rsp_ready`. On `rsp_valid&&rsp_ready`, go to IDLE and clear `rsp_err`.
- `dbg_cr_sel` holds its last value between commands; the execute stage only acts on it when `dbg_cr_wr_en` is high.
- `cpu_stopped` deasserting after accept does not abort the command; it completes normally.
- A new command is never accepted in the RESP cycle, even when `rsp_ready=1`. `cmd_ready` returns the cycle after the response handshake.

## Timing
- Accept edge = E0.
- READ: `rsp_valid` high in the cycle after E1 (2 cycles after accept).
- WRITE, SET, CLEAR: `dbg_cr_wr_en` high in the cycle after E1; `rsp_valid` high after E3 (4 cycles).
- Rejected command: `rsp_valid` high after E0 (1 cycle).
- Throughput: one command per (latency+1) cycles at minimum.
- Reset values: state IDLE, `cmd_ready=1` after reset, `rsp_valid=0`, `rsp_err=0`, `rsp_data=0`, `dbg_cr_sel=0`, `dbg_cr_wr_val=0`, `dbg_cr_wr_en=0`.
- Reset mid-operation:
  - Abandons the command with no response.
  - `dbg_cr_wr_en` is low from the cycle after the reset edge.
  - A write strobe already presented in the reset cycle is not retracted; the execute stage's own reset priority applies.
- `rst` has priority over every handshake in the same cycle.

## Structure
- A shared defines header holds the op encodings (`DBG_CR_OP_READ/WRITE/SET/CLEAR`), state encodings and the read-only CR index constant (3'h7), for reuse by the debug controller.
- Single module; no sub-module is warranted. The RMW data path is a 2:1 mux plus AND/OR inline.

## Test plan
- **Read while stopped:** READ sel=0 with CR0=0x00001000 -> `rsp_valid` 2 cycles after accept, `rsp_data=0x00001000`, `rsp_err=0`, no `dbg_cr_wr_en`.
- **Write with read-back:** WRITE sel=0, data=0x1234567F -> one `dbg_cr_wr_en` pulse with `wr_val=0x1234567F`, `rsp_data=0x12345640`, latency 4.
- **SET/CLEAR on PSR:** PSR=0x001; SET sel=1, data=0x010 -> `wr_val=0x011`. Then CLEAR data=0x001 -> `wr_val=0x010`, `rsp_data=0x010`.
- **Rejections:** `cpu_stopped=0`, READ -> `rsp_err=1` after 1 cycle, no strobe. `cpu_stopped=1`, WRITE sel=7 -> `rsp_err=1`, no strobe.
- **Response backpressure:** `rsp_ready` low for 5 cycles -> `rsp_valid` and `rsp_data` stable, `cmd_ready=0` throughout. `cmd_ready=1` the cycle after the handshake.
- **Reset mid-op:** assert `rst` during WRITE state -> next cycle IDLE, `dbg_cr_wr_en=0`, `rsp_valid=0`. A subsequent READ completes normally.

Source files
------------

// File: rtl/oldland_dbg_cr_master_pkg.sv
// Shared encodings for the debug control-register port: command ops, master
// FSM states and the read-only CR index. Also used by the debug controller.
package oldland_dbg_cr_master_pkg;

  localparam logic [1:0] DBG_CR_OP_READ  = 2'b00;
  localparam logic [1:0] DBG_CR_OP_WRITE = 2'b01;
  localparam logic [1:0] DBG_CR_OP_SET   = 2'b10;
  localparam logic [1:0] DBG_CR_OP_CLEAR = 2'b11;

  // CR7 always reads as zero and never accepts writes.
  localparam logic [2:0] DBG_CR_RO_SEL = 3'h7;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSelect   = 3'd1,
    StWrite    = 3'd2,
    StReadback = 3'd3,
    StResp     = 3'd4
  } dbg_cr_state_e;

  // Write data for a modifying op given the current register value.
  function automatic logic [31:0] dbg_cr_rmw(input logic [1:0]  op,
                                             input logic [31:0] old,
                                             input logic [31:0] data);
    logic [31:0] res;
    unique case (op)
      DBG_CR_OP_SET:   res = old | data;
      DBG_CR_OP_CLEAR: res = old & ~data;
      default:         res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/oldland_dbg_cr_master.sv
// Debug-side initiator for the execute stage's control-register port.
// Runs one READ/WRITE/SET/CLEAR per command while the CPU is stopped and
// returns exactly one response (read value or post-write read-back).
module oldland_dbg_cr_master
  import oldland_dbg_cr_master_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_stopped,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_sel,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [2:0]  dbg_cr_sel,
  input  logic [31:0] dbg_cr_val,
  output logic [31:0] dbg_cr_wr_val,
  output logic        dbg_cr_wr_en
);

  dbg_cr_state_e state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [2:0]    sel_q, sel_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   wr_val_q, wr_val_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  // State and datapath registers; synchronous reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= DBG_CR_OP_READ;
      sel_q      <= 3'h0;
      data_q     <= 32'h0;
      wr_val_q   <= 32'h0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      wr_val_q   <= wr_val_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state and datapath update for the command sequence.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sel_d      = sel_q;
    data_d     = data_q;
    wr_val_d   = wr_val_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          sel_d  = cmd_sel;
          data_d = cmd_data;
          if (!cpu_stopped || (cmd_op != DBG_CR_OP_READ && cmd_sel == DBG_CR_RO_SEL)) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = 32'h0;
            state_d    = StResp;
          end else begin
            rsp_err_d = 1'b0;
            state_d   = StSelect;
          end
        end
      end
      StSelect: begin
        if (op_q == DBG_CR_OP_READ) begin
          rsp_data_d = dbg_cr_val;
          state_d    = StResp;
        end else begin
          wr_val_d = dbg_cr_rmw(op_q, dbg_cr_val, data_q);
          state_d  = StWrite;
        end
      end
      StWrite: begin
        state_d = StReadback;
      end
      StReadback: begin
        // Read-back may differ from the written value where CR bits are hardwired.
        rsp_data_d = dbg_cr_val;
        state_d    = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_err_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign cmd_ready     = (state_q == StIdle);
  assign rsp_valid     = (state_q == StResp);
  assign dbg_cr_wr_en  = (state_q == StWrite);
  assign dbg_cr_sel    = sel_q;
  assign dbg_cr_wr_val = wr_val_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_oldland_dbg_cr_master.sv
// Bench for oldland_dbg_cr_master: hand-written vector table, reset sequences
// and randomized commands against a register-file level reference model.
module tb_oldland_dbg_cr_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_stopped = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [2:0]  cmd_sel = 3'h0;
  logic [31:0] cmd_data = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [2:0]  dbg_cr_sel;
  logic [31:0] dbg_cr_val;
  logic [31:0] dbg_cr_wr_val;
  logic        dbg_cr_wr_en;

  oldland_dbg_cr_master dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_stopped  (cpu_stopped),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_sel      (cmd_sel),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .dbg_cr_sel   (dbg_cr_sel),
    .dbg_cr_val   (dbg_cr_val),
    .dbg_cr_wr_val(dbg_cr_wr_val),
    .dbg_cr_wr_en (dbg_cr_wr_en)
  );

  always #5 clk = ~clk;

  // Execute-stage control-register file stand-in.
  function automatic logic [31:0] cr_mask(input logic [2:0] s);
    case (s)
      3'd0:       return 32'hFFFF_FFC0;
      3'd5, 3'd6: return 32'hFFFF_FFFC;
      3'd7:       return 32'h0;
      default:    return 32'hFFFF_FFFF;
    endcase
  endfunction

  logic [31:0] mem [8];
  logic        pl_en = 1'b0;
  logic [2:0]  pl_sel = 3'h0;
  logic [31:0] pl_val = 32'h0;
  int          strobe_total = 0;
  logic [31:0] last_wr_val = 32'h0;

  assign dbg_cr_val = mem[dbg_cr_sel];

  // Register file update: preload port for the bench, else the debug write strobe.
  always @(posedge clk) begin
    if (pl_en) mem[pl_sel] <= pl_val & cr_mask(pl_sel);
    else if (dbg_cr_wr_en) mem[dbg_cr_sel] <= dbg_cr_wr_val & cr_mask(dbg_cr_sel);
    if (dbg_cr_wr_en) begin
      strobe_total <= strobe_total + 1;
      last_wr_val  <= dbg_cr_wr_val;
    end
  end

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] model_cr [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic preload(input logic [2:0] s, input logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_sel = s; pl_val = v;
    @(posedge clk);
    #1 pl_en = 1'b0;
    model_cr[s] = v & cr_mask(s);
  endtask

  // Reference: expected outcome of one command from the CR contents alone.
  task automatic model_cmd(input bit st, input logic [1:0] op, input logic [2:0] sel,
                           input logic [31:0] d, output bit e_err, output logic [31:0] e_data,
                           output int e_lat, output int e_strb, output logic [31:0] e_wv);
    e_wv = 32'h0;
    if (!st || (op != 2'b00 && sel == 3'd7)) begin
      e_err = 1'b1; e_data = 32'h0; e_lat = 1; e_strb = 0;
    end else if (op == 2'b00) begin
      e_err = 1'b0; e_data = model_cr[sel]; e_lat = 2; e_strb = 0;
    end else begin
      case (op)
        2'b01:   e_wv = d;
        2'b10:   e_wv = model_cr[sel] | d;
        default: e_wv = model_cr[sel] & ~d;
      endcase
      model_cr[sel] = e_wv & cr_mask(sel);
      e_err = 1'b0; e_data = model_cr[sel]; e_lat = 4; e_strb = 1;
    end
  endtask

  // Issue one command, hold off the response for bp cycles, and check everything.
  task automatic do_cmd(input string tag, input bit st, input logic [1:0] op,
                        input logic [2:0] sel, input logic [31:0] d, input int bp,
                        input bit e_err, input logic [31:0] e_data, input int e_lat,
                        input int e_strb, input logic [31:0] e_wv);
    int s0, lat, w;
    logic [31:0] d0;
    logic e0;
    bit ok;
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    if (!cmd_ready) begin check({tag, ".ready_timeout"}, 32'd0, 32'd1); return; end
    s0 = strobe_total;
    cpu_stopped = st; cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_data = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cpu_stopped = 1'($urandom_range(0, 1));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    check({tag, ".lat"}, 32'(lat), 32'(e_lat));
    if (!rsp_valid) return;
    check({tag, ".err"}, {31'h0, rsp_err}, {31'h0, e_err});
    check({tag, ".data"}, rsp_data, e_data);
    check({tag, ".strobes"}, 32'(strobe_total - s0), 32'(e_strb));
    if (e_strb == 1) check({tag, ".wr_val"}, last_wr_val, e_wv);
    d0 = rsp_data; e0 = rsp_err;
    ok = !cmd_ready;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== d0 || rsp_err !== e0 || cmd_ready) ok = 1'b0;
    end
    check({tag, ".rsp_hold"}, {31'h0, ok}, 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, ".after_hs"}, {29'h0, cmd_ready, rsp_valid, rsp_err}, 32'h4);
  endtask

  typedef struct {
    bit          st;
    logic [1:0]  op;
    logic [2:0]  sel;
    logic [31:0] d;
    int          bp;
    bit          e_err;
    logic [31:0] e_data;
    int          e_lat;
    int          e_strb;
    logic [31:0] e_wv;
  } vec_t;

  vec_t vecs [8];

  initial begin
    bit          e_err;
    logic [31:0] e_data, e_wv, d;
    int          e_lat, e_strb;
    logic [1:0]  op;
    logic [2:0]  sel;
    bit          st;

    vecs[0] = '{1, 2'b00, 3'd0, 32'h0,         0, 0, 32'h0000_1000, 2, 0, 32'h0};
    vecs[1] = '{1, 2'b01, 3'd0, 32'h1234_567F, 1, 0, 32'h1234_5640, 4, 1, 32'h1234_567F};
    vecs[2] = '{1, 2'b10, 3'd1, 32'h0000_0010, 0, 0, 32'h0000_0011, 4, 1, 32'h0000_0011};
    vecs[3] = '{1, 2'b11, 3'd1, 32'h0000_0001, 2, 0, 32'h0000_0010, 4, 1, 32'h0000_0010};
    vecs[4] = '{0, 2'b00, 3'd1, 32'h0,         5, 1, 32'h0,         1, 0, 32'h0};
    vecs[5] = '{1, 2'b01, 3'd7, 32'hFFFF_FFFF, 0, 1, 32'h0,         1, 0, 32'h0};
    vecs[6] = '{1, 2'b00, 3'd7, 32'h0,         0, 0, 32'h0,         2, 0, 32'h0};
    vecs[7] = '{1, 2'b01, 3'd5, 32'hFFFF_FFFF, 5, 0, 32'hFFFF_FFFC, 4, 1, 32'hFFFF_FFFF};

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset.ctrl", {28'h0, cmd_ready, rsp_valid, rsp_err, dbg_cr_wr_en}, 32'h8);
    check("reset.rsp_data", rsp_data, 32'h0);
    check("reset.sel", {29'h0, dbg_cr_sel}, 32'h0);
    check("reset.wr_val", dbg_cr_wr_val, 32'h0);

    for (int i = 0; i < 8; i++) preload(3'(i), 32'h0);
    preload(3'd0, 32'h0000_1000);
    preload(3'd1, 32'h0000_0001);

    for (int i = 0; i < 8; i++)
      do_cmd($sformatf("vec%0d", i), vecs[i].st, vecs[i].op, vecs[i].sel, vecs[i].d,
             vecs[i].bp, vecs[i].e_err, vecs[i].e_data, vecs[i].e_lat, vecs[i].e_strb,
             vecs[i].e_wv);

    // Reset while the write strobe is up: strobe lands, no response follows.
    preload(3'd2, 32'h0);
    @(negedge clk);
    cpu_stopped = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_sel = 3'd2;
    cmd_data = 32'hA5A5_0F0F;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid.strobe", {31'h0, dbg_cr_wr_en}, 32'd1);
    check("rstmid.wr_val", dbg_cr_wr_val, 32'hA5A5_0F0F);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_cr[2] = 32'hA5A5_0F0F;
    @(negedge clk);
    check("rstmid.after", {29'h0, cmd_ready, rsp_valid, dbg_cr_wr_en}, 32'h4);
    check("rstmid.sel", {29'h0, dbg_cr_sel}, 32'h0);
    model_cmd(1'b1, 2'b00, 3'd2, 32'h0, e_err, e_data, e_lat, e_strb, e_wv);
    do_cmd("rstmid.read", 1'b1, 2'b00, 3'd2, 32'h0, 0, e_err, e_data, e_lat, e_strb, e_wv);

    // Randomized commands against the model.
    for (int i = 0; i < 8; i++) preload(3'(i), $urandom);
    for (int i = 0; i < 150; i++) begin
      st  = ($urandom_range(0, 3) != 0);
      op  = 2'($urandom_range(0, 3));
      sel = 3'($urandom_range(0, 7));
      d   = $urandom;
      model_cmd(st, op, sel, d, e_err, e_data, e_lat, e_strb, e_wv);
      do_cmd($sformatf("rnd%0d", i), st, op, sel, d, int'($urandom_range(0, 2)),
             e_err, e_data, e_lat, e_strb, e_wv);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
